// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core and its instruction-memory loader.
// The loader's state encoding, stream framing and fetch widths live here.
package mips_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int INSTR_WITDTH = 32;

    // Program stream framing: a little-endian word count, payload, one XOR byte.
    localparam int HDR_BYTES = 2;
    localparam int CHK_WIDTH = 8;

    typedef logic [8*HDR_BYTES-1:0] word_count_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CHK,
        RUN,
        ERR
    } load_state_t;

    // Drops one stream byte into its little-endian lane of a 32-bit word.
    function automatic logic [31:0] set_lane(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream from the host side plus the core's fetch port.
// The loader takes the slave view; whoever feeds the stream takes master.
interface imem_loader_if;
    import mips_pkg::*;

    logic                    load_start;
    logic                    load_valid;
    logic [7:0]              load_byte;
    logic                    load_ready;
    logic                    load_done;
    logic                    load_err;
    logic                    core_rst_n;
    logic [PC_WIDTH-1:0]     pc;
    logic [INSTR_WITDTH-1:0] instr;

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_byte,
        input  pc,
        output load_ready,
        output load_done,
        output load_err,
        output core_rst_n,
        output instr
    );

    modport master (
        output load_start,
        output load_valid,
        output load_byte,
        output pc,
        input  load_ready,
        input  load_done,
        input  load_err,
        input  core_rst_n,
        input  instr
    );

endinterface

// File: rtl/imem_ram.sv
// Instruction word store: one synchronous write port, one asynchronous read port.
// Every word clears on reset so unloaded locations always read as zero.
module imem_ram #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, XOR-checked program image into instruction memory and
// holds the core in reset until a complete, checksum-clean image is present.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input logic          clk,
    input logic          rst_n,
    imem_loader_if.slave bus
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int LIM_W = 8*HDR_BYTES + 2;

    localparam word_count_t   DEPTH_N   = word_count_t'(DEPTH_WORDS);
    localparam word_count_t   COUNT_ONE = word_count_t'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [1:0]    LANE_ONE  = 2'd1;

    load_state_t          state_reg, state_next;
    word_count_t          count_reg, count_next;
    logic [AW:0]          word_ptr_reg, word_ptr_next;
    logic [1:0]           byte_cnt_reg, byte_cnt_next;
    logic [31:0]          asm_reg, asm_next;
    logic [CHK_WIDTH-1:0] xor_reg, xor_next;
    logic                 done_reg, err_reg, core_rst_n_reg;

    logic        xfer;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
    word_count_t hdr_count;
    word_count_t words_after;
    logic        pc_in_image;

    assign bus.load_ready = state_reg inside {HDR0, HDR1, DATA, CHK};
    assign xfer           = bus.load_valid && bus.load_ready;
    assign hdr_count      = {bus.load_byte, count_reg[7:0]};
    assign words_after    = word_count_t'(word_ptr_reg) + COUNT_ONE;
    assign mem_wdata      = set_lane(asm_reg, byte_cnt_reg, bus.load_byte);

    // Next-state and datapath decode; load_start overrides any byte in flight.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        word_ptr_next = word_ptr_reg;
        byte_cnt_next = byte_cnt_reg;
        asm_next      = asm_reg;
        xor_next      = xor_reg;
        mem_we        = 1'b0;

        if (bus.load_start) begin
            state_next    = HDR0;
            count_next    = '0;
            word_ptr_next = '0;
            byte_cnt_next = '0;
            asm_next      = '0;
            xor_next      = '0;
        end else if (xfer) begin
            case (state_reg)
                HDR0: begin
                    count_next[7:0] = bus.load_byte;
                    state_next      = HDR1;
                end
                HDR1: begin
                    count_next = hdr_count;
                    if (hdr_count > DEPTH_N) begin
                        state_next = ERR;
                    end else if (hdr_count == '0) begin
                        state_next = CHK;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    xor_next      = xor_reg ^ bus.load_byte;
                    byte_cnt_next = byte_cnt_reg + LANE_ONE;
                    asm_next      = mem_wdata;
                    if (byte_cnt_reg == 2'd3) begin
                        mem_we        = 1'b1;
                        asm_next      = '0;
                        word_ptr_next = word_ptr_reg + PTR_ONE;
                        if (words_after == count_reg) begin
                            state_next = CHK;
                        end
                    end
                end
                CHK: begin
                    state_next = (bus.load_byte == xor_reg) ? RUN : ERR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg      <= '0;
            word_ptr_reg   <= '0;
            byte_cnt_reg   <= '0;
            asm_reg        <= '0;
            xor_reg        <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            core_rst_n_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            word_ptr_reg   <= word_ptr_next;
            byte_cnt_reg   <= byte_cnt_next;
            asm_reg        <= asm_next;
            xor_reg        <= xor_next;
            done_reg       <= (state_next == RUN);
            err_reg        <= (state_next == ERR);
            core_rst_n_reg <= (state_next == RUN);
        end
    end

    assign bus.load_done  = done_reg;
    assign bus.load_err   = err_reg;
    assign bus.core_rst_n = core_rst_n_reg;

    imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (word_ptr_reg[AW-1:0]),
        .wdata (mem_wdata),
        .raddr (bus.pc[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Fetches past the loaded image return a NOP even if the RAM index aliases.
    assign pc_in_image = (bus.pc[PC_WIDTH-1:LIM_W] == '0) &&
                         (bus.pc[LIM_W-1:0] < {count_reg, 2'b00});

    assign bus.instr = ((state_reg == RUN) && pc_in_image) ? ram_rdata : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised and directed program streams checked every cycle against a
// stream-parsing reference model of the loader.
module tb_imem_loader;
    import mips_pkg::*;

    localparam int DEPTH = 64;

    typedef logic [7:0] bq_t [$];
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_ERR} mmode_t;

    logic clk = 1'b0;
    logic rst_n;

    imem_loader_if bus();

    imem_loader #(
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: bytes accepted since the last start, parsed from scratch.
    mmode_t      m_mode;
    int          m_n;
    logic [31:0] m_mem [DEPTH];
    logic [7:0]  acc [$];
    bit          last_xfer;

    int  n_vec = 0;
    int  n_err = 0;
    bq_t sq;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_n    = 0;
        acc.delete();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    endtask

    task automatic model_step();
        int k;
        logic [7:0] x;
        last_xfer = 1'b0;
        if (rst_n !== 1'b1) return;
        if (bus.load_start) begin
            m_mode = M_LOAD;
            m_n    = 0;
            acc.delete();
            return;
        end
        if (m_mode != M_LOAD || !bus.load_valid) return;
        last_xfer = 1'b1;
        acc.push_back(bus.load_byte);
        k = acc.size();
        if (k == 2) begin
            m_n = int'({acc[1], acc[0]});
            if (m_n > DEPTH) m_mode = M_ERR;
        end else if (k > 2 && k <= 2 + 4*m_n) begin
            if ((k - 2) % 4 == 0)
                m_mem[(k-2)/4 - 1] = {acc[k-1], acc[k-2], acc[k-3], acc[k-4]};
        end else if (k == 3 + 4*m_n) begin
            x = 8'h00;
            for (int j = 2; j < k - 1; j++) x = x ^ acc[j];
            m_mode = (x == acc[k-1]) ? M_RUN : M_ERR;
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        int idx;
        idx = int'(pc >> 2);
        if (m_mode == M_RUN && (pc >> 2) < 32'(m_n)) return m_mem[idx];
        return 32'h0;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check1("load_ready", bus.load_ready, m_mode == M_LOAD);
        check1("load_done", bus.load_done, m_mode == M_RUN);
        check1("load_err", bus.load_err, m_mode == M_ERR);
        check1("core_rst_n", bus.core_rst_n, m_mode == M_RUN);
        check32("instr", bus.instr, exp_instr(bus.pc));
    end

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 7) == 0) return 32'($urandom);
        return 32'($urandom_range(0, 4*DEPTH + 15));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_byte  = 8'($urandom);
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_byte  = 8'($urandom);
            bus.pc         = rand_pc();
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    // Feeds sq; at stop_at accepted bytes either aborts with load_start or just returns.
    task automatic send(input int gap_pct, input int stop_at, input bit do_abort);
        int i;
        int guard;
        int bound;
        i     = 0;
        guard = 0;
        bound = 8*sq.size() + 100;
        while (i < sq.size() && guard < bound) begin
            if (i == stop_at) begin
                if (do_abort) pulse_start();
                bus.load_valid = 1'b0;
                return;
            end
            bus.load_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.load_byte  = bus.load_valid ? sq[i] : 8'($urandom);
            bus.pc         = rand_pc();
            tick();
            if (last_xfer) i++;
            guard++;
            if (m_mode != M_LOAD) break;
        end
        bus.load_valid = 1'b0;
        if (guard >= bound) begin
            n_err++;
            $display("FAIL send_bound: stream stalled at byte %0d of %0d", i, sq.size());
        end
    endtask

    task automatic build(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        sq.delete();
        sq.push_back(8'(n));
        sq.push_back(8'(n >> 8));
        if (n > DEPTH) begin
            sq.push_back(8'($urandom));
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            sq.push_back(b);
            x = x ^ b;
        end
        sq.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    endtask

    task automatic probe(input string name, input logic [31:0] pc, input logic [31:0] exp);
        bus.pc = pc;
        #1;
        check32(name, bus.instr, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        int stop;
        model_reset();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'h00;
        bus.pc         = 32'h0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check1("rst_ready", bus.load_ready, 1'b0);
        check1("rst_done", bus.load_done, 1'b0);
        check1("rst_core_rst_n", bus.core_rst_n, 1'b0);
        idle(6);
        check1("idle_hold_ready", bus.load_ready, 1'b0);

        // Two-word image; checksum of these payload bytes is 0x4D.
        pulse_start();
        sq = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h48, 8'h09, 8'h01, 8'h4D};
        send(30, -1, 1'b0);
        #1;
        check1("good_done", bus.load_done, 1'b1);
        check1("good_err", bus.load_err, 1'b0);
        check1("good_core_rst_n", bus.core_rst_n, 1'b1);
        probe("good_pc0", 32'd0, 32'h2008_0005);
        probe("good_pc4", 32'd4, 32'h0109_4820);
        probe("good_pc8", 32'd8, 32'h0000_0000);
        probe("good_pc3", 32'd3, 32'h2008_0005);
        probe("good_pc7", 32'd7, 32'h0109_4820);
        probe("good_pc_alias", 32'h0000_0100, 32'h0000_0000);
        idle(5);

        // Same image, bad checksum.
        pulse_start();
        sq = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h48, 8'h09, 8'h01, 8'h65};
        send(0, -1, 1'b0);
        #1;
        check1("bad_err", bus.load_err, 1'b1);
        check1("bad_done", bus.load_done, 1'b0);
        check1("bad_core_rst_n", bus.core_rst_n, 1'b0);
        probe("bad_pc0", 32'd0, 32'h0);
        probe("bad_pc4", 32'd4, 32'h0);
        idle(4);

        // Header one word past capacity.
        pulse_start();
        sq = '{8'h41, 8'h00, 8'h12};
        send(0, -1, 1'b0);
        #1;
        check1("ovf_err", bus.load_err, 1'b1);
        check1("ovf_ready", bus.load_ready, 1'b0);
        idle(4);

        // Abort after three payload bytes, then a one-word image.
        pulse_start();
        sq = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h00};
        send(0, 5, 1'b1);
        sq = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9};
        send(20, -1, 1'b0);
        #1;
        check1("restart_done", bus.load_done, 1'b1);
        probe("restart_pc0", 32'd0, 32'hCAFE_F00D);
        probe("restart_pc4", 32'd4, 32'h0);
        idle(4);

        // Reset in the middle of DATA.
        pulse_start();
        build(8, 1'b0);
        send(0, 11, 1'b0);
        bus.pc = 32'd0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check1("midrst_ready", bus.load_ready, 1'b0);
        check1("midrst_done", bus.load_done, 1'b0);
        check1("midrst_err", bus.load_err, 1'b0);
        check1("midrst_core_rst_n", bus.core_rst_n, 1'b0);
        check32("midrst_instr", bus.instr, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        idle(6);
        check1("postrst_idle", bus.load_ready, 1'b0);

        // Empty image.
        pulse_start();
        sq = '{8'h00, 8'h00, 8'h00};
        send(0, -1, 1'b0);
        #1;
        check1("empty_done", bus.load_done, 1'b1);
        probe("empty_pc0", 32'd0, 32'h0);
        idle(3);

        // Full-depth image.
        pulse_start();
        build(DEPTH, 1'b0);
        send(10, -1, 1'b0);
        #1;
        check1("full_done", bus.load_done, 1'b1);
        idle(20);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = DEPTH;
                2:       n = DEPTH + 1 + $urandom_range(0, 300);
                default: n = $urandom_range(1, DEPTH);
            endcase
            build(n, $urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, 60);
            stop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, sq.size() - 1) : -1;
            pulse_start();
            send(gap, stop, 1'b1);
            idle($urandom_range(2, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
